// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbg_pkg
// Brief    : Run-control state encoding and width helpers for dbg_halt_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STEP = 2'd1,
    ST_HALT = 2'd2,
    ST_DUMP = 2'd3
  } dbg_state_t;

  localparam int c_cycle_cnt_w = 32;

  // Index width that never collapses to zero bits for single-entry configs.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_bp_match.sv
`default_nettype none
// ============================================================================
// Module   : dbg_bp_match
// Brief    : Breakpoint slot registers, pc comparators and lowest-index encoder.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_bp_match
  import dbg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_BP = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ADDR_W-1:0]            pc,
  input  logic                         bp_we,
  input  logic [idx_w(NUM_BP)-1:0]     bp_idx,
  input  logic [ADDR_W-1:0]            bp_addr,
  input  logic                         bp_en,
  output logic                         match,
  output logic [idx_w(NUM_BP)-1:0]     match_idx
);

  localparam int c_idx_w = idx_w(NUM_BP);

  logic [NUM_BP-1:0]  w_hit;
  logic [c_idx_w-1:0] w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_slot
      logic [ADDR_W-1:0] r_addr;
      logic              r_en;

      // Out-of-range indices match no slot and are silently dropped.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_addr <= '0;
          r_en   <= 1'b0;
        end else if (bp_we && (int'(bp_idx) == gi)) begin
          r_addr <= bp_addr;
          r_en   <= bp_en;
        end
      end

      assign w_hit[gi] = r_en & (r_addr == pc);
    end
  endgenerate

  always_comb begin
    w_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (w_hit[i]) w_idx = i[c_idx_w-1:0];
    end
  end

  assign match     = |w_hit;
  assign match_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/dbg_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbg_halt_ctrl
// Brief    : CPU run control: clock-enable gating, breakpoints, single-step and
//            halted-memory dump sweep. Define DBG_CYCLE_CNT_EN for cycle_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_halt_ctrl
  import dbg_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int NUM_BP       = 4,
  parameter int DUMP_DEPTH   = 256,
  parameter int RUN_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ADDR_W-1:0]             pc,
  input  logic                          run,
  input  logic                          step,
  input  logic                          halt_req,
  input  logic                          bp_we,
  input  logic [idx_w(NUM_BP)-1:0]      bp_idx,
  input  logic [ADDR_W-1:0]             bp_addr,
  input  logic                          bp_en,
  input  logic                          dump_start,
  output logic                          cpu_clk_en,
  output logic                          debug,
  output logic                          halted,
  output logic                          hit_valid,
  output logic [idx_w(NUM_BP)-1:0]      hit_idx,
  output logic [idx_w(DUMP_DEPTH)-1:0]  dump_addr,
  output logic                          dump_valid,
  output logic                          dump_done
`ifdef DBG_CYCLE_CNT_EN
  ,
  output logic [c_cycle_cnt_w-1:0]      cycle_cnt
`endif
);

  localparam int                 c_idx_w       = idx_w(NUM_BP);
  localparam int                 c_dump_w      = idx_w(DUMP_DEPTH);
  localparam logic [c_dump_w-1:0] c_dump_last  = c_dump_w'(DUMP_DEPTH - 1);
  localparam dbg_state_t         c_reset_state = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALT;

  dbg_state_t          r_state;
  dbg_state_t          w_next_state;
  logic                w_bp_raw;
  logic [c_idx_w-1:0]  w_bp_idx;
  logic                w_match;
  logic                w_dump_last;
  logic                r_skip;
  logic                r_debug;
  logic                r_halted;
  logic                r_hit_valid;
  logic [c_idx_w-1:0]  r_hit_idx;
  logic [c_dump_w-1:0] r_dump_addr;
  logic                r_dump_done;

  dbg_bp_match #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk       (clk),
    .rstn      (rstn),
    .pc        (pc),
    .bp_we     (bp_we),
    .bp_idx    (bp_idx),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .match     (w_bp_raw),
    .match_idx (w_bp_idx)
  );

  // Skip masks the breakpoint the CPU is parked on so a resume can leave it.
  assign w_match     = w_bp_raw & ~r_skip;
  assign w_dump_last = (r_dump_addr == c_dump_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_reset_state;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:  if (w_match || halt_req) w_next_state = ST_HALT;
      ST_STEP: w_next_state = ST_HALT;
      ST_HALT: begin
        if (run)             w_next_state = ST_RUN;
        else if (step)       w_next_state = ST_STEP;
        else if (dump_start) w_next_state = ST_DUMP;
      end
      ST_DUMP: if (w_dump_last) w_next_state = ST_HALT;
      default: w_next_state = c_reset_state;
    endcase
  end

  always_comb begin
    cpu_clk_en = 1'b0;
    dump_valid = 1'b0;
    case (r_state)
      ST_RUN:  cpu_clk_en = ~w_match & ~halt_req;
      ST_STEP: cpu_clk_en = 1'b1;
      ST_DUMP: dump_valid = 1'b1;
      default: ;
    endcase
  end

  // debug/halted come straight from flops so cpu_top sees a clean mux select.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_debug  <= (c_reset_state != ST_RUN);
      r_halted <= (c_reset_state == ST_HALT);
    end else begin
      r_debug  <= (w_next_state == ST_HALT) || (w_next_state == ST_DUMP);
      r_halted <= (w_next_state == ST_HALT);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hit_valid <= 1'b0;
      r_hit_idx   <= '0;
      r_skip      <= 1'b0;
    end else begin
      if (r_state == ST_RUN && w_match) begin
        r_hit_valid <= 1'b1;
        r_hit_idx   <= w_bp_idx;
      end else if (r_state == ST_RUN && halt_req) begin
        r_hit_valid <= 1'b0;
      end else if (r_state == ST_HALT && !run && step) begin
        r_hit_valid <= 1'b0;
      end

      if (r_state == ST_HALT && (run || step)) r_skip <= 1'b1;
      else if (cpu_clk_en)                     r_skip <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dump_addr <= '0;
      r_dump_done <= 1'b0;
    end else if (r_state == ST_DUMP) begin
      r_dump_addr <= w_dump_last ? '0 : r_dump_addr + 1'b1;
      r_dump_done <= w_dump_last;
    end else begin
      r_dump_addr <= '0;
      r_dump_done <= 1'b0;
    end
  end

`ifdef DBG_CYCLE_CNT_EN
  logic [c_cycle_cnt_w-1:0] r_cycle_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_cycle_cnt <= '0;
    else if (cpu_clk_en) r_cycle_cnt <= r_cycle_cnt + 1'b1;
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

  assign debug     = r_debug;
  assign halted    = r_halted;
  assign hit_valid = r_hit_valid;
  assign hit_idx   = r_hit_idx;
  assign dump_addr = r_dump_addr;
  assign dump_done = r_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_dbg_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_halt_ctrl
// Brief    : Directed scenarios plus randomized run-control traffic against a
//            behavioural run-control model; the bench plays the CPU pc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_halt_ctrl;

  localparam int c_num_bp = 4;
  localparam int c_depth  = 8;
  localparam int M_RUN = 0, M_STEP = 1, M_HALT = 2, M_DUMP = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc = '0;
  logic        run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic        bp_we = 1'b0, bp_en = 1'b0, dump_start = 1'b0;
  logic [1:0]  bp_idx = '0;
  logic [31:0] bp_addr = '0;

  logic        cpu_clk_en, debug, halted, hit_valid, dump_valid, dump_done;
  logic [1:0]  hit_idx;
  logic [2:0]  dump_addr;
`ifdef DBG_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the run-control behaviour
  int          m_mode;
  bit          m_skip, m_hv, m_done, e_en;
  int          m_hi, m_pos;
  logic [31:0] m_addr [c_num_bp];
  bit          m_en   [c_num_bp];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  dbg_halt_ctrl #(
    .ADDR_W       (32),
    .NUM_BP       (c_num_bp),
    .DUMP_DEPTH   (c_depth),
    .RUN_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc         (pc),
    .run        (run),
    .step       (step),
    .halt_req   (halt_req),
    .bp_we      (bp_we),
    .bp_idx     (bp_idx),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .dump_start (dump_start),
    .cpu_clk_en (cpu_clk_en),
    .debug      (debug),
    .halted     (halted),
    .hit_valid  (hit_valid),
    .hit_idx    (hit_idx),
    .dump_addr  (dump_addr),
    .dump_valid (dump_valid),
    .dump_done  (dump_done)
`ifdef DBG_CYCLE_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_skip = 0; m_hv = 0; m_hi = 0; m_pos = 0; m_done = 0;
    m_cnt  = '0;
    for (int i = 0; i < c_num_bp; i++) begin
      m_addr[i] = '0;
      m_en[i]   = 0;
    end
    pc = '0;
  endtask

  function automatic int lowest_hit();
    if (m_skip) return -1;
    for (int i = 0; i < c_num_bp; i++)
      if (m_en[i] && m_addr[i] == pc) return i;
    return -1;
  endfunction

  task automatic model_step(input int h);
    bit done_n = 0;
    if (e_en) m_skip = 0;
    case (m_mode)
      M_RUN: begin
        if (h >= 0) begin m_mode = M_HALT; m_hv = 1; m_hi = h; end
        else if (halt_req) begin m_mode = M_HALT; m_hv = 0; end
      end
      M_STEP: m_mode = M_HALT;
      M_HALT: begin
        if (run)             begin m_mode = M_RUN;  m_skip = 1; end
        else if (step)       begin m_mode = M_STEP; m_skip = 1; m_hv = 0; end
        else if (dump_start) m_mode = M_DUMP;
      end
      default: begin
        if (m_pos == c_depth - 1) begin m_pos = 0; done_n = 1; m_mode = M_HALT; end
        else m_pos++;
      end
    endcase
    m_done = done_n;
    if (bp_we && bp_idx < c_num_bp) begin
      m_addr[bp_idx] = bp_addr;
      m_en[bp_idx]   = bp_en;
    end
    if (e_en) begin
      m_cnt = m_cnt + 1;
      pc    = (pc + 32'd4) & 32'hFF;
    end
  endtask

  // Compare mid-cycle, then advance the model 1 ns after the clock edge.
  task automatic cycle();
    int h;
    #3;
    h    = lowest_hit();
    e_en = (m_mode == M_RUN && h < 0 && !halt_req) || (m_mode == M_STEP);
    check("cpu_clk_en", 32'(cpu_clk_en), 32'(e_en));
    check("debug",      32'(debug),      32'(m_mode == M_HALT || m_mode == M_DUMP));
    check("halted",     32'(halted),     32'(m_mode == M_HALT));
    check("hit_valid",  32'(hit_valid),  32'(m_hv));
    check("hit_idx",    32'(hit_idx),    32'(m_hi));
    check("dump_valid", 32'(dump_valid), 32'(m_mode == M_DUMP));
    check("dump_addr",  32'(dump_addr),  32'(m_pos));
    check("dump_done",  32'(dump_done),  32'(m_done));
`ifdef DBG_CYCLE_CNT_EN
    check("cycle_cnt",  cycle_cnt,       m_cnt);
`endif
    @(posedge clk);
    #1;
    if (!rstn) model_reset();
    else       model_step(h);
  endtask

  task automatic wr_bp(input int idx, input logic [31:0] addr, input bit en);
    bp_we = 1; bp_idx = 2'(idx); bp_addr = addr; bp_en = en;
    cycle();
    bp_we = 0;
  endtask

  task automatic pulse_run();
    run = 1; cycle(); run = 0;
  endtask

  task automatic run_until_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    model_reset();
    cycle();
    cycle();
    rstn = 1;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_hit_valid", 32'(hit_valid), 32'd0);

    // Breakpoint at 0xC4: CPU must park there without executing it
    wr_bp(0, 32'hC4, 1);
    run_until_halt("bp0_halt", 100);
    check("bp0_hit_valid", 32'(hit_valid), 32'd1);
    check("bp0_hit_idx", 32'(hit_idx), 32'd0);
    check("bp0_clk_en", 32'(cpu_clk_en), 32'd0);

    // Resume leaves 0xC4 and halts there again after pc wraps
    pulse_run();
    cycle();
    check("resume_left", 32'(halted), 32'd0);
    run_until_halt("bp0_rehit", 200);
    check("rehit_idx", 32'(hit_idx), 32'd0);

    // Two slots on the same pc: the lower index wins
    wr_bp(0, 32'hC4, 0);
    wr_bp(1, 32'h20, 1);
    wr_bp(3, 32'h20, 1);
    pulse_run();
    run_until_halt("bp13_halt", 200);
    check("bp13_hit_idx", 32'(hit_idx), 32'd1);

    step = 1; cycle(); step = 0;
    check("step_clk_en", 32'(cpu_clk_en), 32'd1);
    check("step_hit_clr", 32'(hit_valid), 32'd0);
    cycle();
    check("step_rehalt", 32'(halted), 32'd1);

    // Dump sweep
    dump_start = 1; cycle(); dump_start = 0;
    for (int i = 0; i < c_depth; i++) begin
      check("dump_seq_addr", 32'(dump_addr), 32'(i));
      check("dump_seq_valid", 32'(dump_valid), 32'd1);
      cycle();
    end
    check("dump_done_pulse", 32'(dump_done), 32'd1);
    check("dump_back_halt", 32'(halted), 32'd1);
    cycle();

    // External halt, run/step collision, reset during dump
    pulse_run();
    halt_req = 1;
    repeat (3) cycle();
    check("hreq_halted", 32'(halted), 32'd1);
    check("hreq_no_hit", 32'(hit_valid), 32'd0);
    halt_req = 0;
    run = 1; step = 1; cycle(); run = 0; step = 0;
    check("run_wins", 32'(halted), 32'd0);
    halt_req = 1; repeat (2) cycle(); halt_req = 0;
    dump_start = 1; cycle(); dump_start = 0;
    repeat (3) cycle();
    rstn = 0;
    #1;
    model_reset();
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_addr", 32'(dump_addr), 32'd0);
    check("rst_debug", 32'(debug), 32'd0);
    cycle();
    rstn = 1;

`ifdef DBG_CYCLE_CNT_EN
    repeat (10) cycle();
    halt_req = 1;
    repeat (3) cycle();
    check("cnt_ten", cycle_cnt, 32'd10);
    repeat (4) cycle();
    check("cnt_frozen", cycle_cnt, 32'd10);
    halt_req = 0;
`endif

    // Randomized run-control traffic
    for (int k = 0; k < 3000; k++) begin
      run        = ($urandom_range(0, 19) == 0);
      step       = ($urandom_range(0, 19) == 0);
      dump_start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      bp_we   = ($urandom_range(0, 19) == 0);
      bp_idx  = 2'($urandom_range(0, 3));
      bp_addr = 32'($urandom_range(0, 63)) * 32'd4;
      bp_en   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
